// File: rtl/npc_duty_sequencer.sv
// ---------------------------------------------------------------------------
// npc_duty_sequencer
// Duty-cycle sequencer for one PWM-with-dead-time leg of the NPC converter.
// Commands are taken over valid/ready and applied only at PWM period
// boundaries. A slew-limited ramp gives soft start, soft stop and duty
// changes. A fault forces the leg off at once and latches until a clear
// that arrives after the hold time has elapsed.
//
// Optional feature macro: DUTY_CLAMP_EN
//   defined   : captured command is clamped to [DMIN, DMAX]
//   undefined : captured command is used unmodified
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cmd_duty     in   requested duty (DW bits)
//   cmd_valid    in   command valid
//   cmd_ready    out  command accepted when valid && ready (low in FAULT)
//   enable       in   run request level
//   fault        in   fault level, synchronous to clk
//   fault_clr    in   one-cycle fault clear request
//   d            out  registered duty to the PWM
//   pwm_en       out  registered leg enable
//   period_start out  high during the last count of each period
//   state        out  IDLE=0, RAMP=1, RUN=2, FAULT=3
//   busy         out  high while ramping
// ---------------------------------------------------------------------------
module npc_duty_sequencer #(
  parameter int DW         = 10,
  parameter int STEP       = 4,
  parameter int FAULT_HOLD = 16,
  parameter int DMIN       = 8,
  parameter int DMAX       = 1015
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cmd_duty,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          enable,
  input  logic          fault,
  input  logic          fault_clr,
  output logic [DW-1:0] d,
  output logic          pwm_en,
  output logic          period_start,
  output logic [1:0]    state,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};
  localparam logic [DW:0]   STEP_W  = (DW+1)'(STEP);
  localparam logic [7:0]    HOLD_W  = 8'(FAULT_HOLD);

  state_t        state_r, state_n_s;
  logic [DW-1:0] cnt_r;
  logic [DW-1:0] d_r, d_n_s;
  logic          pwm_en_r, pwm_en_n_s;
  logic [DW-1:0] target_r, target_n_s;
  logic [7:0]    hold_r, hold_n_s;
  logic [DW-1:0] tgt_eff_s;
  logic [DW-1:0] step_s;
  logic          handshake_s;

  // Move cur toward tgt by at most STEP; done in DW+1 bits so it cannot wrap.
  function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                 input logic [DW-1:0] tgt);
    logic [DW:0] c, t, res;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) begin
      if ((t - c) <= STEP_W) res = t;
      else                   res = c + STEP_W;
    end else begin
      if ((c - t) <= STEP_W) res = t;
      else                   res = c - STEP_W;
    end
    return res[DW-1:0];
  endfunction

`ifdef DUTY_CLAMP_EN
  localparam logic [DW-1:0] DMIN_W = DW'(DMIN);
  localparam logic [DW-1:0] DMAX_W = DW'(DMAX);

  // Keep the captured duty inside the minimum-pulse window around dead time.
  function automatic logic [DW-1:0] capture_duty(input logic [DW-1:0] cmd);
    if (cmd < DMIN_W)      return DMIN_W;
    else if (cmd > DMAX_W) return DMAX_W;
    else                   return cmd;
  endfunction
`else
  // Captured duty is taken as-is.
  function automatic logic [DW-1:0] capture_duty(input logic [DW-1:0] cmd);
    return cmd;
  endfunction
`endif

  assign period_start = (cnt_r == CNT_MAX);
  assign cmd_ready    = (state_r != ST_FAULT);
  assign busy         = (state_r == ST_RAMP);
  assign d            = d_r;
  assign pwm_en       = pwm_en_r;
  assign state        = state_r;

  assign handshake_s = cmd_valid && cmd_ready;
  assign tgt_eff_s   = enable ? target_r : {DW{1'b0}};
  assign step_s      = step_toward(d_r, tgt_eff_s);

  // Next-state and next-output logic; fault overrides everything else.
  always_comb begin
    state_n_s  = state_r;
    d_n_s      = d_r;
    pwm_en_n_s = pwm_en_r;
    target_n_s = target_r;
    hold_n_s   = hold_r;
    if (fault) begin
      // A persisting fault keeps re-entering FAULT, so the hold time is
      // measured from the cycle the fault goes away.
      state_n_s  = ST_FAULT;
      d_n_s      = {DW{1'b0}};
      pwm_en_n_s = 1'b0;
      target_n_s = {DW{1'b0}};
      hold_n_s   = 8'd0;
    end else begin
      // The boundary update below reads target_r, so a command captured on
      // a boundary cycle only takes effect at the following boundary.
      if (handshake_s) begin
        target_n_s = capture_duty(cmd_duty);
      end else begin
        target_n_s = target_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (period_start && enable) begin
            state_n_s  = ST_RAMP;
            pwm_en_n_s = 1'b1;
            d_n_s      = step_s;
          end else begin
            d_n_s      = {DW{1'b0}};
            pwm_en_n_s = 1'b0;
          end
        end
        ST_RAMP: begin
          if (period_start) begin
            d_n_s = step_s;
            if ((step_s == tgt_eff_s) && enable) begin
              state_n_s = ST_RUN;
            end else if ((step_s == {DW{1'b0}}) && !enable) begin
              state_n_s  = ST_IDLE;
              pwm_en_n_s = 1'b0;
            end else begin
              state_n_s = ST_RAMP;
            end
          end else begin
            state_n_s = ST_RAMP;
          end
        end
        ST_RUN: begin
          if (period_start && (tgt_eff_s != d_r)) begin
            state_n_s = ST_RAMP;
            d_n_s     = step_s;
          end else begin
            state_n_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          d_n_s      = {DW{1'b0}};
          pwm_en_n_s = 1'b0;
          if (fault_clr && (hold_r == HOLD_W)) begin
            state_n_s = ST_IDLE;
          end else if (period_start && (hold_r != HOLD_W)) begin
            hold_n_s = hold_r + 8'd1;
          end else begin
            hold_n_s = hold_r;
          end
        end
        default: begin
          state_n_s  = ST_FAULT;
          d_n_s      = {DW{1'b0}};
          pwm_en_n_s = 1'b0;
          target_n_s = {DW{1'b0}};
          hold_n_s   = 8'd0;
        end
      endcase
    end
  end

  // State, duty, target, hold and period counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {DW{1'b0}};
      d_r      <= {DW{1'b0}};
      pwm_en_r <= 1'b0;
      target_r <= {DW{1'b0}};
      hold_r   <= 8'd0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= cnt_r + DW'(1);
      d_r      <= d_n_s;
      pwm_en_r <= pwm_en_n_s;
      target_r <= target_n_s;
      hold_r   <= hold_n_s;
    end
  end

endmodule
